// File: rtl/ram_arbiter_o9.sv
// ram_arbiter_o9: three-state sequencer sharing the single-port 1024x32 program/data RAM between fetch and load/store.
// Define RAM_ARB_LOADER_EN to add a write-only boot-loader port with strict priority over both.
module ram_arbiter_o9 #(
  parameter int DEPTH = 1024,
  parameter int AW    = 16,
  parameter int DW    = 32
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
`ifdef RAM_ARB_LOADER_EN
  input  logic          l_req,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_ack,
`endif
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_data,
  output logic          ram_wren,
  input  logic [DW-1:0] ram_q,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic [1:0] {SRC_F, SRC_D, SRC_L} src_t;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t        state, state_nxt;
  src_t          gsrc, src_p0;
  logic          grant, gwe, goor;
  logic [AW-1:0] gaddr;
  logic [DW-1:0] gwdata;
  logic          oor_p0;
  logic          rr_ptr;  // 0: fetch wins a tie, 1: data wins a tie

  always_comb begin
    grant  = 1'b0;
    gsrc   = SRC_F;
    gwe    = 1'b0;
    gaddr  = f_addr;
    gwdata = '0;
`ifdef RAM_ARB_LOADER_EN
    if (l_req) begin
      grant  = 1'b1;
      gsrc   = SRC_L;
      gwe    = 1'b1;
      gaddr  = l_addr;
      gwdata = l_wdata;
    end else
`endif
    if (f_req && (!d_req || !rr_ptr)) begin
      grant = 1'b1;
      gsrc  = SRC_F;
    end else if (d_req) begin
      grant  = 1'b1;
      gsrc   = SRC_D;
      gwe    = d_we;
      gaddr  = d_addr;
      gwdata = d_wdata;
    end
    goor = {1'b0, gaddr} >= DEPTH_W;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = grant ? ACCESS : IDLE;
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      src_p0      <= SRC_F;
      oor_p0      <= 1'b0;
      rr_ptr      <= 1'b0;
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
      f_ack       <= 1'b0;
      f_rdata     <= '0;
      d_ack       <= 1'b0;
      d_rdata     <= '0;
      d_err       <= 1'b0;
`ifdef RAM_ARB_LOADER_EN
      l_ack       <= 1'b0;
`endif
    end else begin
      case (state)
        // IDLE -> ACCESS: latch the winner onto the RAM bus
        IDLE: if (grant) begin
          src_p0      <= gsrc;
          oor_p0      <= goor;
          ram_address <= gaddr;
          ram_data    <= gwdata;
          ram_wren    <= gwe && !goor;
          if (gsrc != SRC_L) rr_ptr <= (gsrc == SRC_F);
        end
        // ACCESS -> DONE: write commits, read data captured for the winner
        ACCESS: begin
          ram_wren <= 1'b0;
          case (src_p0)
            SRC_F: begin
              f_ack   <= 1'b1;
              f_rdata <= oor_p0 ? '0 : ram_q;
            end
            SRC_D: begin
              d_ack   <= 1'b1;
              d_err   <= oor_p0;
              d_rdata <= oor_p0 ? '0 : ram_q;
            end
`ifdef RAM_ARB_LOADER_EN
            SRC_L: l_ack <= 1'b1;
`endif
            default: ;
          endcase
        end
        // DONE -> IDLE: acks last exactly one cycle
        DONE: begin
          f_ack <= 1'b0;
          d_ack <= 1'b0;
          d_err <= 1'b0;
`ifdef RAM_ARB_LOADER_EN
          l_ack <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter_o9.sv
// Scoreboard bench for ram_arbiter_o9 with a behavioural RAM; loader scenario runs only with RAM_ARB_LOADER_EN.
module tb_ram_arbiter_o9;
  localparam int DEPTH = 1024;
  localparam int AW    = 16;
  localparam int DW    = 32;

  logic          clock = 1'b0;
  logic          resetn;
  logic          f_req, f_ack, d_req, d_we, d_ack, d_err;
  logic [AW-1:0] f_addr, d_addr;
  logic [DW-1:0] f_rdata, d_wdata, d_rdata;
  logic          l_req, l_ack;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data, ram_q;
  logic          ram_wren, busy;

  ram_arbiter_o9 #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clock(clock), .resetn(resetn),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
`ifdef RAM_ARB_LOADER_EN
    .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_ack(l_ack),
`endif
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q), .busy(busy)
  );
`ifndef RAM_ARB_LOADER_EN
  assign l_ack = 1'b0;
`endif

  always #5 clock = ~clock;

  // Behavioural RAM: synchronous write, combinational read; out-of-range reads return a marker.
  logic [DW-1:0] mem   [0:DEPTH-1];
  logic [DW-1:0] model [0:DEPTH-1];
  always @(posedge clock)
    if (ram_wren && int'(ram_address) < DEPTH) mem[ram_address[9:0]] <= ram_data;
  assign ram_q = (int'(ram_address) < DEPTH) ? mem[ram_address[9:0]] : 32'hBAD0_BAD0;

  typedef struct {
    logic [1:0]    port;   // 0 fetch, 1 data, 2 loader
    logic [DW-1:0] rdata;
    logic          err;
    logic          chk_rd;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   total = 0;
  int   bad   = 0;

  // Scoreboard: every ack pops the oldest expectation
  always @(negedge clock) begin
    if (resetn === 1'b1) begin
      if (f_ack) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL sb_fetch: unexpected f_ack rdata=%h", f_rdata);
        end else begin
          me = sb.pop_front();
          if (me.port !== 2'd0 || f_rdata !== me.rdata || d_err !== 1'b0) begin
            bad++;
            $display("FAIL sb_fetch: got port=0 rdata=%h d_err=%b, want port=%0d rdata=%h d_err=0",
                     f_rdata, d_err, me.port, me.rdata);
          end
        end
      end
      if (d_ack) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL sb_data: unexpected d_ack rdata=%h", d_rdata);
        end else begin
          me = sb.pop_front();
          if (me.port !== 2'd1 || d_err !== me.err || (me.chk_rd && d_rdata !== me.rdata)) begin
            bad++;
            $display("FAIL sb_data: got port=1 rdata=%h err=%b, want port=%0d rdata=%h err=%b",
                     d_rdata, d_err, me.port, me.rdata, me.err);
          end
        end
      end
      if (l_ack) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL sb_loader: unexpected l_ack");
        end else begin
          me = sb.pop_front();
          if (me.port !== 2'd2) begin
            bad++; $display("FAIL sb_loader: got port=2, want port=%0d", me.port);
          end
        end
      end
    end
  end

  function automatic exp_t make_exp(input int port, input logic we, input logic [AW-1:0] addr);
    exp_t e;
    logic oor;
    oor      = int'(addr) >= DEPTH;
    e.port   = 2'(port);
    e.err    = (port == 1) && oor;
    e.chk_rd = !(we && !oor);
    e.rdata  = (oor || we) ? '0 : model[addr[9:0]];
    return e;
  endfunction

  // Drives one request at an IDLE negedge, returns ack latency (-1 on timeout), wren and busy cycle counts.
  task automatic do_req(input int port, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, output int lat, output int wrens, output int busys);
    sb.push_back(make_exp(port, we, addr));
    if ((we || port == 2) && int'(addr) < DEPTH) model[addr[9:0]] = wdata;
    case (port)
      0:       begin f_addr = addr; f_req = 1'b1; end
      1:       begin d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1; end
      default: begin l_addr = addr; l_wdata = wdata; l_req = 1'b1; end
    endcase
    lat = -1; wrens = 0; busys = 0;
    for (int n = 1; n <= 20 && lat < 0; n++) begin
      @(negedge clock);
      if (ram_wren) wrens++;
      if (busy) busys++;
      if ((port == 0 && f_ack) || (port == 1 && d_ack) || (port == 2 && l_ack)) lat = n;
    end
    f_req = 1'b0; d_req = 1'b0; l_req = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    f_req = 1'b0; d_req = 1'b0; l_req = 1'b0; d_we = 1'b0;
    f_addr = '0; d_addr = '0; d_wdata = '0; l_addr = '0; l_wdata = '0;
    repeat (3) @(negedge clock);
    total++;
    if ({f_ack, d_ack, d_err, ram_wren, busy} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl: ack/err/wren/busy=%b, want 00000", {f_ack, d_ack, d_err, ram_wren, busy});
    end
    total++;
    if (f_rdata !== '0 || d_rdata !== '0) begin
      bad++; $display("FAIL reset_rdata: f_rdata=%h d_rdata=%h, want 0", f_rdata, d_rdata);
    end
    total++;
    if (ram_address !== '0 || ram_data !== '0) begin
      bad++; $display("FAIL reset_ram: addr=%h data=%h, want 0", ram_address, ram_data);
    end
    resetn = 1'b1;
    @(negedge clock);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_idle: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_single_fetch;
    int lat, wr, bz;
    do_req(0, 1'b0, 16'd5, '0, lat, wr, bz);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL fetch_latency: got %0d, want 2", lat); end
    total++;
    if (bz !== 2) begin bad++; $display("FAIL fetch_busy: busy cycles %0d, want 2", bz); end
    total++;
    if (f_ack !== 1'b0 || busy !== 1'b0 || wr !== 0) begin
      bad++; $display("FAIL fetch_after: f_ack=%b busy=%b wrens=%0d, want 0 0 0", f_ack, busy, wr);
    end
  endtask

  task automatic test_store_load;
    int lat, wr, bz;
    do_req(1, 1'b1, 16'd10, 32'h1234_5678, lat, wr, bz);
    total++;
    if (wr !== 1 || lat !== 2) begin
      bad++; $display("FAIL store_wren: wren cycles=%0d lat=%0d, want 1 2", wr, lat);
    end
    total++;
    if (mem[10] !== 32'h1234_5678) begin
      bad++; $display("FAIL store_mem: word10=%h, want 12345678", mem[10]);
    end
    do_req(1, 1'b0, 16'd10, '0, lat, wr, bz);
    total++;
    if (lat !== 2 || wr !== 0) begin
      bad++; $display("FAIL load_timing: lat=%0d wrens=%0d, want 2 0", lat, wr);
    end
  endtask

  task automatic test_contention;
    int acks, ack_n[4];
    logic ack_p[4];
    test_reset();
    f_addr = 16'd20; d_addr = 16'd21; d_we = 1'b0;
    for (int i = 0; i < 4; i++) sb.push_back(make_exp(i % 2, 1'b0, (i % 2) ? 16'd21 : 16'd20));
    f_req = 1'b1; d_req = 1'b1;
    acks = 0;
    for (int n = 1; n <= 40 && acks < 4; n++) begin
      @(negedge clock);
      if (f_ack || d_ack) begin
        ack_n[acks] = n; ack_p[acks] = d_ack; acks++;
      end
    end
    f_req = 1'b0; d_req = 1'b0;
    @(negedge clock);
    total++;
    if (acks !== 4) begin
      bad++; $display("FAIL contention_count: acks=%0d, want 4", acks);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (ack_n[i] !== 2 + 3 * i || ack_p[i] !== logic'(i % 2)) begin
          bad++; $display("FAIL contention_ack%0d: cycle=%0d port=%0d, want cycle=%0d port=%0d",
                          i, ack_n[i], ack_p[i], 2 + 3 * i, i % 2);
        end
      end
    end
  endtask

  task automatic test_out_of_range;
    int lat, wr, bz;
    do_req(1, 1'b1, 16'd1024, 32'hCAFE_F00D, lat, wr, bz);
    total++;
    if (wr !== 0 || lat !== 2) begin
      bad++; $display("FAIL oor_store: wren cycles=%0d lat=%0d, want 0 2", wr, lat);
    end
    total++;
    if (mem[0] !== model[0]) begin
      bad++; $display("FAIL oor_word0: word0=%h, want %h", mem[0], model[0]);
    end
    do_req(1, 1'b0, 16'd1025, '0, lat, wr, bz);
    do_req(0, 1'b0, 16'hFFFF, '0, lat, wr, bz);
    total++;
    if (lat !== 2 || wr !== 0) begin
      bad++; $display("FAIL oor_fetch: lat=%0d wrens=%0d, want 2 0", lat, wr);
    end
  endtask

  task automatic test_reset_mid_write;
    int acks;
    d_we = 1'b1; d_addr = 16'd3; d_wdata = 32'h0BAD_F00D; d_req = 1'b1;
    @(negedge clock);
    total++;
    if (ram_wren !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL midrst_access: wren=%b busy=%b, want 1 1", ram_wren, busy);
    end
    resetn = 1'b0;
    #1;
    total++;
    if ({ram_wren, busy, d_ack, f_ack, d_err} !== 5'b0 || ram_address !== '0 || ram_data !== '0) begin
      bad++; $display("FAIL midrst_outputs: wren=%b busy=%b acks=%b%b addr=%h data=%h, want all 0",
                      ram_wren, busy, d_ack, f_ack, ram_address, ram_data);
    end
    d_req = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    acks = 0;
    repeat (6) begin
      @(negedge clock);
      if (d_ack) acks++;
    end
    total++;
    if (acks !== 0 || mem[3] !== model[3]) begin
      bad++; $display("FAIL midrst_lost: d_acks=%0d word3=%h, want 0 %h", acks, mem[3], model[3]);
    end
  endtask

`ifdef RAM_ARB_LOADER_EN
  task automatic test_loader;
    int acks, lcnt;
    logic [1:0] seq[5];
    test_reset();
    f_addr = 16'd20; d_addr = 16'd21; d_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(make_exp(2, 1'b1, 16'(100 + i)));
      model[100 + i] = 32'hA000_0000 + i;
    end
    sb.push_back(make_exp(0, 1'b0, 16'd20));
    sb.push_back(make_exp(1, 1'b0, 16'd21));
    l_addr = 16'd100; l_wdata = 32'hA000_0000;
    l_req = 1'b1; f_req = 1'b1; d_req = 1'b1;
    acks = 0; lcnt = 0;
    for (int n = 1; n <= 60 && acks < 5; n++) begin
      @(negedge clock);
      if (l_ack) begin
        seq[acks] = 2'd2; acks++; lcnt++;
        if (lcnt < 3) begin l_addr = 16'(100 + lcnt); l_wdata = 32'hA000_0000 + lcnt; end
        else l_req = 1'b0;
      end
      if (f_ack) begin seq[acks] = 2'd0; acks++; f_req = 1'b0; end
      if (d_ack) begin seq[acks] = 2'd1; acks++; d_req = 1'b0; end
    end
    l_req = 1'b0; f_req = 1'b0; d_req = 1'b0;
    @(negedge clock);
    total++;
    if (acks !== 5 || seq[3] !== 2'd0 || seq[4] !== 2'd1) begin
      bad++; $display("FAIL loader_order: acks=%0d last=%0d,%0d, want 5 0,1", acks, seq[3], seq[4]);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (mem[100 + i] !== model[100 + i]) begin
        bad++; $display("FAIL loader_word%0d: got %h, want %h", 100 + i, mem[100 + i], model[100 + i]);
      end
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]   = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
      model[i] = mem[i];
    end
    mem[5] = 32'hDEAD_BEEF; model[5] = 32'hDEAD_BEEF;
    test_reset();
    test_single_fetch();
    test_store_load();
    test_contention();
    test_out_of_range();
    test_reset_mid_write();
`ifdef RAM_ARB_LOADER_EN
    test_loader();
`endif
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL sb_drain: %0d expected acks never seen, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
